pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch/control FSM that sequences the 8-bit program counter by issuing its en/wr/acall
//   strobes and its jump/call target byte.
//  Handshakes with instruction ROM (req/ack) and execute unit (start/done).
//  Decodes JMP/CALL/RET/HLT and tracks hardware call-stack depth.
//  Sits between PC, ROM and ALU/execute stage in the CPU top.
// PARAMETERS
//  STACK_DEPTH  8   return-address slots in the PC call stack
//  DEPTH_W      4   width of depth counter; must hold 0..STACK_DEPTH
// PORTS
//  clock       in   1  single system clock, all logic on posedge
//  rst         in   1  synchronous, active-high reset
//  run         in   1  leave IDLE and start fetching (level, sampled in IDLE)
//  rom_req     out  1  ROM read request; held until rom_ack
//  rom_ack     in   1  ROM data valid this cycle
//  rom_data    in   8  ROM read data
//  ir          out  8  latched instruction register
//  exec_start  out  1  1-cycle pulse: execute unit begins ir
//  exec_done   in   1  execute unit finished; sampled only in EXEC
//  pc_en       out  1  PC increment strobe, 1-cycle pulse
//  pc_wr       out  1  PC load strobe, 1-cycle pulse
//  pc_acall    out  1  with pc_wr: push and load; alone: pop
//  pc_data     out  8  jump/call target, valid while pc_wr=1
//  depth       out  DEPTH_W  current call-stack depth
//  halted      out  1  HLT executed; sticky until rst
//  fault       out  1  stack guard trip; sticky until rst (STACK_GUARD_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; ir=8'h00, depth=0. rst has priority over every event.
//  Opcode classes (ir[7:5]): 3'b111 JMP, 3'b110 CALL, 3'b101 RET. ir==8'h00 is HLT.
//   All other values are ALU ops.
//  States and transitions:
//   IDLE: wait run=1 -> FETCH.
//   FETCH: rom_req=1; on rom_ack, ir<=rom_data -> DECODE.
//   DECODE: 1 cycle.
//    - HLT -> HALT.
//    - JMP/CALL: pc_en pulse to step to the operand byte -> OPFETCH.
//    - RET -> PCUPD.
//    - ALU -> EXEC with exec_start pulse.
//   OPFETCH: rom_req=1; on rom_ack, target<=rom_data -> PCUPD.
//   EXEC: wait exec_done -> PCUPD. exec_start is not re-asserted.
//   PCUPD: exactly one strobe set, then -> FETCH.
//    - ALU: pc_en.
//    - JMP: pc_wr, pc_data=target.
//    - CALL: pc_wr+pc_acall, pc_data=target, depth+1.
//    - RET: pc_acall only, depth-1.
//   HALT: halted=1, no strobes, terminal until rst.
//   FAULT: fault=1, no strobes, terminal until rst.
//  Latency, ALU instruction with zero-wait ROM and exec_done in the first EXEC cycle:
//   FETCH..PCUPD = 4 cycles.
//  Strobe rules: pc_en, pc_wr and pc_acall never overlap except pc_wr+pc_acall for CALL.
//   Each is high for at most 1 cycle per instruction.
//  rom_req deasserts in the cycle after rom_ack. A rom_ack outside FETCH/OPFETCH is ignored.
//  rst mid-handshake: rom_req and exec_start drop in the next cycle and the FSM returns to IDLE.
//   The PC is reset at top level together with this block.
// CONFIGURATION
//  STACK_GUARD_EN defined:
//   - CALL at depth==STACK_DEPTH, or RET at depth==0, goes DECODE -> FAULT.
//   - No PC strobe is issued and depth is unchanged.
//  STACK_GUARD_EN undefined:
//   - No check; fault is tied 0.
//   - depth wraps modulo 2^DEPTH_W.
// STRUCTURE
//  Shared package pc_seq_pkg:
//   - state enum (IDLE, FETCH, DECODE, OPFETCH, EXEC, PCUPD, HALT, FAULT)
//   - opcode-class localparams (OPC_JMP, OPC_CALL, OPC_RET, OPC_HLT)
//  Single module, no sub-modules. Depth counter stays inline.
// TESTING
//  1. rst=1 for 2 cycles, then run=1, ROM acks every cycle, ir stream 8'h21:
//     exec_start once, then pc_en pulses once 4 cycles after rom_req rises.
//  2. JMP 8'hE0 then operand 8'h40: pc_en in DECODE, then pc_wr=1 with pc_data=8'h40.
//     pc_acall=0, depth stays 0.
//  3. CALL 8'hC0 + operand 8'h10, then RET 8'hA0:
//     pc_wr+pc_acall with pc_data=8'h10 and depth=1, then pc_acall alone and depth=0.
//  4. 9 nested CALLs with STACK_GUARD_EN: fault=1 at the 9th, no strobe, depth=8.
//     Without the macro depth reads 9.
//  5. rom_ack held 0 for 5 cycles in FETCH, then assert rst:
//     rom_req stays high until rst, then drops and the FSM is in IDLE.
//  6. ir=8'h00: halted=1 and no further rom_req. A later rom_ack or exec_done has no effect.

Source files
------------

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_seq_pkg
// Brief   : Shared state encoding and opcode classes for the PC sequencer.
// Revision: 1.0
// ============================================================================
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPFETCH = 3'd3,
    ST_EXEC    = 3'd4,
    ST_PCUPD   = 3'd5,
    ST_HALT    = 3'd6,
    ST_FAULT   = 3'd7
  } state_t;

  // Flow-control classes live in ir[7:5]; HLT is the all-zero byte.
  localparam logic [2:0] OPC_JMP  = 3'b111;
  localparam logic [2:0] OPC_CALL = 3'b110;
  localparam logic [2:0] OPC_RET  = 3'b101;
  localparam logic [7:0] OPC_HLT  = 8'h00;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Brief   : Fetch/decode/control FSM driving PC strobes, ROM and execute
//           handshakes. Define STACK_GUARD_EN to trap call-stack over/underflow.
// Revision: 1.0
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = 4
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               run,
  output logic               rom_req,
  input  logic               rom_ack,
  input  logic [7:0]         rom_data,
  output logic [7:0]         ir,
  output logic               exec_start,
  input  logic               exec_done,
  output logic               pc_en,
  output logic               pc_wr,
  output logic               pc_acall,
  output logic [7:0]         pc_data,
  output logic [DEPTH_W-1:0] depth,
  output logic               halted,
  output logic               fault
);

  if (STACK_DEPTH >= (1 << DEPTH_W)) begin : g_depth_w_check
    $error("DEPTH_W cannot hold STACK_DEPTH");
  end

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_ir;
  logic [7:0]           r_target;
  logic [DEPTH_W-1:0]   r_depth;

  logic w_hlt, w_jmp, w_call, w_ret, w_trip;

  assign w_hlt  = (r_ir == OPC_HLT);
  assign w_jmp  = (r_ir[7:5] == OPC_JMP);
  assign w_call = (r_ir[7:5] == OPC_CALL);
  assign w_ret  = (r_ir[7:5] == OPC_RET);

`ifdef STACK_GUARD_EN
  assign w_trip = (w_call && (r_depth == DEPTH_W'(STACK_DEPTH))) ||
                  (w_ret  && (r_depth == '0));
  assign fault  = (r_state == ST_FAULT);
`else
  assign w_trip = 1'b0;
  assign fault  = 1'b0;
`endif

  assign ir     = r_ir;
  assign depth  = r_depth;
  assign halted = (r_state == ST_HALT);

  always_comb begin
    w_next     = r_state;
    rom_req    = 1'b0;
    exec_start = 1'b0;
    pc_en      = 1'b0;
    pc_wr      = 1'b0;
    pc_acall   = 1'b0;
    pc_data    = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (run) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        rom_req = 1'b1;
        if (rom_ack) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_hlt) begin
          w_next = ST_HALT;
        end else if (w_trip) begin
          w_next = ST_FAULT;
        end else if (w_jmp || w_call) begin
          // Step the PC past the opcode so the operand byte is fetched next.
          pc_en  = 1'b1;
          w_next = ST_OPFETCH;
        end else if (w_ret) begin
          w_next = ST_PCUPD;
        end else begin
          exec_start = 1'b1;
          w_next     = ST_EXEC;
        end
      end
      ST_OPFETCH: begin
        rom_req = 1'b1;
        if (rom_ack) w_next = ST_PCUPD;
      end
      ST_EXEC: begin
        if (exec_done) w_next = ST_PCUPD;
      end
      ST_PCUPD: begin
        if (w_jmp) begin
          pc_wr   = 1'b1;
          pc_data = r_target;
        end else if (w_call) begin
          pc_wr    = 1'b1;
          pc_acall = 1'b1;
          pc_data  = r_target;
        end else if (w_ret) begin
          pc_acall = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
        w_next = ST_FETCH;
      end
      ST_HALT:  w_next = ST_HALT;
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ir     <= 8'h00;
      r_target <= 8'h00;
      r_depth  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH && rom_ack)   r_ir     <= rom_data;
      if (r_state == ST_OPFETCH && rom_ack) r_target <= rom_data;
      if (r_state == ST_PCUPD) begin
        if (w_call)     r_depth <= r_depth + 1'b1;
        else if (w_ret) r_depth <= r_depth - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_sequencer
// Brief   : Scoreboard bench for pc_sequencer with a queue-fed ROM model.
// Revision: 1.0
// ============================================================================
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic       clock = 1'b0;
  logic       rst, run, rom_ack, exec_done;
  logic [7:0] rom_data;
  logic       rom_req, exec_start, pc_en, pc_wr, pc_acall, halted, fault;
  logic [7:0] ir, pc_data;
  logic [3:0] depth;

  pc_sequencer #(.STACK_DEPTH(8), .DEPTH_W(4)) dut (
    .clock(clock), .rst(rst), .run(run),
    .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
    .ir(ir), .exec_start(exec_start), .exec_done(exec_done),
    .pc_en(pc_en), .pc_wr(pc_wr), .pc_acall(pc_acall), .pc_data(pc_data),
    .depth(depth), .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       es;
    logic       en;
    logic       wr;
    logic       ac;
    logic [7:0] data;
    logic [3:0] dep;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] prog[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic       ack_en   = 1'b1;
  logic       stray_ack = 1'b0;
  logic       given    = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t ev(input logic es, en, wr, ac, input logic [7:0] data,
                             input logic [3:0] dep);
    return '{es: es, en: en, wr: wr, ac: ac, data: data, dep: dep};
  endfunction

  // ROM model: one queued byte per acknowledged request, zero wait states.
  initial begin
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    forever begin
      @(negedge clock);
      if (given && prog.size() > 0) void'(prog.pop_front());
      given    = rom_req && ack_en && (prog.size() > 0) && !rst;
      rom_ack  = given || stray_ack;
      rom_data = given ? prog[0] : 8'h21;
    end
  end

  // Monitor: every strobe cycle must match the next expected event.
  initial begin
    ev_t got;
    forever begin
      @(negedge clock);
      if (!rst && (exec_start || pc_en || pc_wr || pc_acall)) begin
        got = {exec_start, pc_en, pc_wr, pc_acall, pc_data, depth};
        if (exp_q.size() == 0) chk("unexpected strobe", 32'(got), 32'h0);
        else                   chk("strobe event", 32'(got), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; ack_en = 1'b1; stray_ack = 1'b0; exec_done = 1'b1;
    exp_q.delete();
    prog.delete();
    repeat (2) step();
    chk("reset outputs",
        {8'h0, rom_req, exec_start, pc_en, pc_wr, pc_acall, pc_data, ir, depth, halted, fault},
        32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_stop();
    int n = 0;
    while (!(halted || fault) && n < 300) begin
      step();
      n++;
    end
    chk("stop within budget", 32'(n < 300), 32'h1);
  endtask

  task automatic end_test(input string name);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int t0, t1, n;
    rst = 1'b1; run = 1'b0; exec_done = 1'b1;

    // ALU op then HLT, latency FETCH..PCUPD
    do_reset();
    prog = '{8'h21, 8'h00};
    exp_q.push_back(ev(1, 0, 0, 0, 8'h00, 4'd0));
    exp_q.push_back(ev(0, 1, 0, 0, 8'h00, 4'd0));
    run = 1'b1;
    n = 0;
    while (!rom_req && n < 20) begin step(); n++; end
    t0 = cyc;
    while (!pc_en && n < 40) begin step(); n++; end
    t1 = cyc;
    chk("fetch-to-pcupd cycles", t1 - t0 + 1, 4);
    wait_stop();
    chk("alu halted", halted, 1);
    end_test("alu pending");

    // JMP
    do_reset();
    prog = '{8'hE0, 8'h40, 8'h00};
    exp_q.push_back(ev(0, 1, 0, 0, 8'h00, 4'd0));
    exp_q.push_back(ev(0, 0, 1, 0, 8'h40, 4'd0));
    run = 1'b1;
    wait_stop();
    chk("jmp depth", depth, 0);
    end_test("jmp pending");

    // CALL then RET
    do_reset();
    prog = '{8'hC0, 8'h10, 8'hA0, 8'h00};
    exp_q.push_back(ev(0, 1, 0, 0, 8'h00, 4'd0));
    exp_q.push_back(ev(0, 0, 1, 1, 8'h10, 4'd0));
    exp_q.push_back(ev(0, 0, 0, 1, 8'h00, 4'd1));
    run = 1'b1;
    wait_stop();
    chk("call/ret depth", depth, 0);
    end_test("call/ret pending");

    // Nine nested CALLs
    do_reset();
    for (int i = 0; i < 9; i++) begin
      prog.push_back(8'hC0);
      prog.push_back(8'h10 + 8'(i));
    end
    prog.push_back(8'h00);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ev(0, 1, 0, 0, 8'h00, 4'(i)));
      exp_q.push_back(ev(0, 0, 1, 1, 8'h10 + 8'(i), 4'(i)));
    end
`ifndef STACK_GUARD_EN
    exp_q.push_back(ev(0, 1, 0, 0, 8'h00, 4'd8));
    exp_q.push_back(ev(0, 0, 1, 1, 8'h18, 4'd8));
`endif
    run = 1'b1;
    wait_stop();
`ifdef STACK_GUARD_EN
    chk("nest fault", fault, 1);
    chk("nest depth", depth, 8);
    step();
    chk("fault no req", rom_req, 0);
`else
    chk("nest halted", halted, 1);
    chk("nest depth", depth, 9);
`endif
    end_test("nest pending");

    // ROM stall then reset mid-handshake
    do_reset();
    ack_en = 1'b0;
    prog = '{8'h21};
    run = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall rom_req", rom_req, 1);
      step();
    end
    rst = 1'b1;
    step();
    chk("rst drops rom_req", rom_req, 0);
    chk("rst state idle", 32'(dut.r_state), 32'(ST_IDLE));
    rst = 1'b0; run = 1'b0;
    step();
    chk("idle rom_req", rom_req, 0);
    end_test("stall pending");

    // HLT, then stray handshakes
    do_reset();
    prog = '{8'h00};
    run = 1'b1;
    wait_stop();
    chk("hlt halted", halted, 1);
    stray_ack = 1'b1;
    exec_done = 1'b1;
    repeat (3) step();
    stray_ack = 1'b0;
    exec_done = 1'b0;
    step();
    chk("hlt sticky", halted, 1);
    chk("hlt ir", ir, 8'h00);
    chk("hlt no req", rom_req, 0);
    end_test("hlt pending");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
